pw_lock_fsm: RTL
================

# pw_lock_fsm

Parametrised password lock: debounces the raw enter button, collects `DIGITS` entries of `BITS` bits each, and compares them with a compile-time password. After `MAX_FAILS` consecutive wrong codes it enters a timed lockout. It sits between the board switches/button and the seven-segment decoders. It replaces the fixed 4-bit single-digit debouncer + password FSM pair with one generalised block.

## Interface
- `BITS`, 4, width of one password digit (`entradas`).
- `DIGITS`, 4, digits per code.
- `PASSWORD`, 16'h1234, `DIGITS*BITS` bits; digit 0 is the most significant `BITS` bits.
- `DEB_CYCLES`, 50000, consecutive cycles of disagreement needed to flip the debounced level (≥2).
- `MAX_FAILS`, 3, consecutive wrong codes that trigger lockout (≥1).
- `HOLD_CYCLES`, 25000000, cycles spent in OPEN or FAIL.
- `LOCK_CYCLES`, 250000000, cycles spent in LOCKOUT.
- `TIMEOUT_CYCLES`, 250000000, idle cycles allowed during entry (see Configuration).
- `clk` in 1 — single clock.
- `rst_a` in 1 — asynchronous, active-high reset.
- `enable_data` in 1 — raw, bouncy enter button, active-high.
- `entradas` in `BITS` — current digit from the switches.
- `estado_led` out 3 — state code: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5.
- `digit_cnt` out `$clog2(DIGITS+1)` — digits captured so far in the current code.
- `fail_cnt` out `$clog2(MAX_FAILS+1)` — consecutive failures.
- `pass_led` out 1 — high only in OPEN.
- `fail_led` out 1 — high only in FAIL.
- `lock_led` out 1 — high only in LOCKOUT.
- `debouncer_led` out 1 — debounced button level.

## Operation
- **Reset values:** all outputs 0; state IDLE; all counters 0; debounced level 0; synchroniser flops 0.
- **Debouncer**
  - `enable_data` passes through a 2-flop synchroniser.
  - The counter increments each cycle the synchronised value differs from the debounced level, and clears whenever they agree.
  - When the count reaches `DEB_CYCLES`, the level flips and the counter clears.
  - A rising edge of the level produces a one-cycle internal strobe `stb`.
- **IDLE**
  - On `stb`: capture `entradas` as digit 0, set `digit_cnt`=1, go to ENTRY.
  - If `DIGITS`==1, go directly to CHECK instead.
- **ENTRY**
  - On `stb`: compare `entradas` with `PASSWORD` digit `digit_cnt` and OR any mismatch into a sticky `bad` flag, then increment `digit_cnt`.
  - When the count reaches `DIGITS`, go to CHECK.
  - Every digit is always collected; an early mismatch is never revealed.
- **CHECK** (exactly 1 cycle)
  - If `bad`=0: go to OPEN and clear `fail_cnt`.
  - If `bad`=1: increment `fail_cnt` (saturating at `MAX_FAILS`). Go to LOCKOUT if the new value equals `MAX_FAILS`, otherwise to FAIL.
  - Clear `digit_cnt` and `bad` in either case.
- **OPEN / FAIL:** hold for `HOLD_CYCLES`, then go to IDLE.
- **LOCKOUT:** hold for `LOCK_CYCLES`, then clear `fail_cnt` and go to IDLE.
- **Ignored strobes:** `stb` has no effect in CHECK, OPEN, FAIL and LOCKOUT. A press is not queued.
- **Digit comparison:** digit i is `PASSWORD[(DIGITS-1-i)*BITS +: BITS]`.
- **Reset mid-operation:** `rst_a` returns everything to the reset values immediately. `fail_cnt` is lost, so a reset also ends a lockout.

## Timing
- Raw button stable high from edge k:
  - `debouncer_led` rises after edge k+2+`DEB_CYCLES`.
  - `stb` is high for that one cycle.
  - `estado_led`/`digit_cnt` update at the following edge.
- `entradas` is sampled on the `stb` cycle.
- The last digit's `stb` leads to CHECK one edge later and to OPEN/FAIL/LOCKOUT one edge after that.
- OPEN and FAIL last exactly `HOLD_CYCLES` cycles; LOCKOUT lasts exactly `LOCK_CYCLES` cycles.
- One shared dwell counter serves OPEN, FAIL, LOCKOUT and the entry timeout. Its width is sized for the largest of `HOLD_CYCLES`, `LOCK_CYCLES` and `TIMEOUT_CYCLES`, and it clears on every state change.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Configuration
- `PW_LOCK_TIMEOUT_EN` defined:
  - In ENTRY, the dwell counter counts cycles without `stb` and clears on each `stb`.
  - On reaching `TIMEOUT_CYCLES`, the state returns to IDLE and clears `digit_cnt` and `bad`.
  - `fail_cnt` is unchanged and `fail_led` is not asserted.
  - A `stb` on the same cycle as the timeout wins: the digit is captured and the counter clears.
- `PW_LOCK_TIMEOUT_EN` not defined: ENTRY waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `HOLD_CYCLES`=10, `LOCK_CYCLES`=50, `TIMEOUT_CYCLES`=30, `PASSWORD`=16'h1234, `MAX_FAILS`=3.
- **Debounce:** toggle `enable_data` every 2 cycles for 20 cycles, then hold it high → exactly one `stb`. `debouncer_led` rises 6 edges after the stable start.
- **Correct code:** enter 1,2,3,4 → `estado_led` goes 1→2→3. `pass_led` is high for 10 cycles, then state 0, `fail_cnt`=0.
- **Wrong code:** enter 1,2,3,5 → `fail_led` high for 10 cycles, `fail_cnt`=1. Then enter 1,2,3,4 → OPEN, `fail_cnt`=0.
- **Lockout:** three wrong codes → LOCKOUT (state 5), `lock_led` high for 50 cycles. Presses during LOCKOUT leave `digit_cnt`=0. Afterwards state 0, `fail_cnt`=0.
- **Timeout (macro defined):** enter 1,2, then idle for 30 cycles → state 0, `digit_cnt`=0, `fail_cnt` unchanged. With the macro undefined, the state stays 1.
- **Reset mid-entry:** assert `rst_a` after 2 digits with `fail_cnt`=2 → all outputs 0 asynchronously. The next 1,2,3,4 reaches OPEN.

Source files
------------

// File: rtl/pw_lock_fsm.sv
// -----------------------------------------------------------------------------
// pw_lock_fsm
//
// Parametrised password lock. The raw enter button is synchronised and
// debounced. Each rising edge of the debounced level captures one digit from
// the switches. After DIGITS digits the code is compared with PASSWORD. A
// correct code opens the lock for HOLD_CYCLES. A wrong code shows FAIL for
// HOLD_CYCLES. MAX_FAILS consecutive wrong codes cause a LOCKOUT of
// LOCK_CYCLES.
//
// Optional feature (macro PW_LOCK_TIMEOUT_EN):
//   When defined, an entry that sees no press for TIMEOUT_CYCLES is abandoned
//   and the lock returns to IDLE without counting a failure.
//
// Ports:
//   clk           in  single clock
//   rst_a         in  asynchronous reset, active high
//   enable_data   in  raw (bouncy) enter button, active high
//   entradas      in  [BITS] current digit from the switches
//   estado_led    out [3] state code (IDLE=0 .. LOCKOUT=5)
//   digit_cnt     out digits captured in the current code
//   fail_cnt      out consecutive wrong codes
//   pass_led      out high only in OPEN
//   fail_led      out high only in FAIL
//   lock_led      out high only in LOCKOUT
//   debouncer_led out debounced button level
//
// State table:
//   state   | meaning
//   IDLE    | waiting for the first digit
//   ENTRY   | collecting the remaining digits
//   CHECK   | one cycle: judge the collected code
//   OPEN    | correct code, pass_led for HOLD_CYCLES
//   FAIL    | wrong code, fail_led for HOLD_CYCLES
//   LOCKOUT | too many wrong codes, lock_led for LOCK_CYCLES
// -----------------------------------------------------------------------------
module pw_lock_fsm #(
  parameter int                       BITS           = 4,
  parameter int                       DIGITS         = 4,
  parameter logic [DIGITS*BITS-1:0]   PASSWORD       = 16'h1234,
  parameter int                       DEB_CYCLES     = 50000,
  parameter int                       MAX_FAILS      = 3,
  parameter int                       HOLD_CYCLES    = 25000000,
  parameter int                       LOCK_CYCLES    = 250000000,
  parameter int                       TIMEOUT_CYCLES = 250000000
) (
  input  logic                           clk,
  input  logic                           rst_a,
  input  logic                           enable_data,
  input  logic [BITS-1:0]                entradas,
  output logic [2:0]                     estado_led,
  output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                           pass_led,
  output logic                           fail_led,
  output logic                           lock_led,
  output logic                           debouncer_led
);

  localparam int DCW = $clog2(DIGITS + 1);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int DBW = $clog2(DEB_CYCLES + 1);
  localparam int DWELL_HL  = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int DWELL_MAX = (DWELL_HL > TIMEOUT_CYCLES) ? DWELL_HL : TIMEOUT_CYCLES;
  localparam int DWW = $clog2(DWELL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic           sync1_q, sync2_q;
  logic           deb_lvl_q, deb_lvl_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic           stb_q, stb_d;

  always_comb begin
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DBW'(DEB_CYCLES)) begin
        deb_lvl_d = ~deb_lvl_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    // Strobe is registered alongside the level, so it is high exactly in the
    // first cycle the debounced level reads 1.
    stb_d = deb_lvl_d & ~deb_lvl_q;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_lvl_q <= 1'b0;
      deb_cnt_q <= '0;
      stb_q     <= 1'b0;
    end else begin
      sync1_q   <= enable_data;
      sync2_q   <= sync1_q;
      deb_lvl_q <= deb_lvl_d;
      deb_cnt_q <= deb_cnt_d;
      stb_q     <= stb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [DCW-1:0] digit_q, digit_d;
  logic [FCW-1:0] fail_q, fail_d;
  logic           bad_q, bad_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic           pass_q, pass_d;
  logic           failled_q, failled_d;
  logic           lock_q, lock_d;
  logic [BITS-1:0] exp_digit;
  logic [FCW-1:0]  fail_inc;

  // Password digit selected by the number of digits already captured.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == DCW'(i)) begin
        exp_digit = PASSWORD[(DIGITS-1-i)*BITS +: BITS];
      end
    end
  end

  assign fail_inc = (fail_q == FCW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    bad_d   = bad_q;
    dwell_d = dwell_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        dwell_d = '0;
        if (stb_q) begin
          bad_d   = (entradas != PASSWORD[DIGITS*BITS-1 -: BITS]);
          digit_d = DCW'(1);
          state_d = (DIGITS == 1) ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
`ifdef PW_LOCK_TIMEOUT_EN
        // A press on the timeout cycle still counts as a digit.
        if (stb_q) begin
          dwell_d = '0;
          bad_d   = bad_q | (entradas != exp_digit);
          digit_d = digit_q + 1'b1;
          if (digit_q == DCW'(DIGITS-1)) state_d = S_CHECK;
        end else if (dwell_q == DWW'(TIMEOUT_CYCLES-1)) begin
          state_d = S_IDLE;
          digit_d = '0;
          bad_d   = 1'b0;
        end
`else
        dwell_d = '0;
        if (stb_q) begin
          bad_d   = bad_q | (entradas != exp_digit);
          digit_d = digit_q + 1'b1;
          if (digit_q == DCW'(DIGITS-1)) state_d = S_CHECK;
        end
`endif
      end

      S_CHECK: begin
        digit_d = '0;
        bad_d   = 1'b0;
        if (!bad_q) begin
          fail_d  = '0;
          state_d = S_OPEN;
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc == FCW'(MAX_FAILS)) ? S_LOCKOUT : S_FAIL;
        end
      end

      S_OPEN, S_FAIL: begin
        if (dwell_q == DWW'(HOLD_CYCLES-1)) state_d = S_IDLE;
      end

      S_LOCKOUT: begin
        if (dwell_q == DWW'(LOCK_CYCLES-1)) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        digit_d = '0;
        bad_d   = 1'b0;
      end
    endcase

    if (state_d != state_q) dwell_d = '0;

    pass_d    = (state_d == S_OPEN);
    failled_d = (state_d == S_FAIL);
    lock_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= S_IDLE;
      digit_q   <= '0;
      fail_q    <= '0;
      bad_q     <= 1'b0;
      dwell_q   <= '0;
      pass_q    <= 1'b0;
      failled_q <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      fail_q    <= fail_d;
      bad_q     <= bad_d;
      dwell_q   <= dwell_d;
      pass_q    <= pass_d;
      failled_q <= failled_d;
      lock_q    <= lock_d;
    end
  end

  assign estado_led    = state_q;
  assign digit_cnt     = digit_q;
  assign fail_cnt      = fail_q;
  assign pass_led      = pass_q;
  assign fail_led      = failled_q;
  assign lock_led      = lock_q;
  assign debouncer_led = deb_lvl_q;

endmodule
